pe_result_drain: RTL and testbench
==================================

Name: pe_result_drain

Overview:
- Sits directly downstream of the DSPFP32 MAC processing element and consumes its AXI-Stream result port (data plus overflow/underflow user flags).
- In MAC mode the PE emits one running partial sum per accepted A/B pair. This block counts beats, discards intermediate partial sums and keeps only every ACC_LEN-th beat (the completed dot product).
- It ORs the error flags across the whole accumulation window and buffers completed results in a small FIFO toward the array output collector.

Parameters:
- ACC_LEN, 4, beats per accumulation window; legal range 1..65535.
- DEPTH, 4, result FIFO entries; power of 2, at least 2.
- DATA_W, 32, result width (binary32).

Ports:
- aclk  in  1  clock, rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_result_tvalid  in  1  PE result valid.
- s_axis_result_tready  out  1  drain can accept a PE result.
- s_axis_result_tdata  in  DATA_W  PE result (partial or final sum).
- s_axis_result_tuser  in  2  bit0 overflow, bit1 underflow.
- m_axis_tvalid  out  1  completed result available.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tdata  out  DATA_W  completed accumulation result.
- m_axis_tuser  out  2  OR of flags over the window; bit0 overflow, bit1 underflow.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.
- busy  out  1  window in progress (beat_cnt!=0) or FIFO non-empty.

Behaviour:
- Reset, sampled on posedge when aresetn=0:
  - beat_cnt=0, err_acc=0.
  - FIFO read and write pointers and the count cleared; FIFO storage is not cleared.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, fifo_count=0, busy=0.
  - s_axis_result_tready=0 while aresetn=0.
- Reset mid-window discards the partial window and all buffered results. There is no flush beat.
- Input accept: a beat is accepted when s_tvalid & s_tready on a posedge.
- s_tready:
  - 1 when beat_cnt != ACC_LEN-1, because intermediate beats are never stored.
  - When beat_cnt == ACC_LEN-1, s_tready = !full | (m_tvalid & m_tready).
  - The full-and-pop path is combinational from m_axis_tready.
- Accepted beat with beat_cnt < ACC_LEN-1:
  - err_acc |= tuser; beat_cnt++.
  - tdata is dropped.
- Accepted beat with beat_cnt == ACC_LEN-1:
  - Push {tdata, err_acc | tuser} into the FIFO.
  - beat_cnt=0, err_acc=0.
- ACC_LEN=1: every beat is final, err_acc stays 0, and s_tready = !full | pop.
- FIFO:
  - Registered storage; m_tvalid = (count != 0); m_tdata and m_tuser come from the head entry. When empty, m_tdata and m_tuser are the last head-entry contents (don't-care).
  - Pop on m_tvalid & m_tready. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: count unchanged, including when full (throughput 1/cycle) and when count=1.
  - Push when empty and pop in the same cycle is impossible, since m_tvalid=0.
- Latency: final beat accepted at edge N gives m_tvalid=1 with that data after edge N, visible in cycle N+1. Intermediate beats produce no output.
- AXI rule: once m_tvalid=1, m_tdata and m_tuser are held stable until popped.
- busy = (beat_cnt != 0) | (count != 0), registered-state-derived.

Test Plan:
- ACC_LEN=4, m_tready=1, feed 4 beats 1.0, 3.0, 6.0, 10.0 (0x3F800000, 0x40400000, 0x40C00000, 0x41200000) with tuser 0 -> exactly one output 0x41200000, tuser=0, m_tvalid rising the cycle after beat 4.
- ACC_LEN=4, beat 2 has tuser=2'b01 and beat 4 has tuser=2'b10 -> output tuser=2'b11. The next window with clean flags -> output tuser=2'b00.
- DEPTH=4, m_tready=0, push 4 windows -> fifo_count=4.
  - 5th window: beats 1..3 are accepted, beat 4 sees s_tready=0 and stalls.
  - Raise m_tready for 1 cycle -> pop plus push in the same cycle, fifo_count stays 4.
  - Outputs drain in order.
- ACC_LEN=1, continuous valid with m_tready=1 -> one output per cycle, fifo_count never exceeds 1, s_tready held 1.
- Assert aresetn=0 for 1 cycle after 2 beats of a window with 2 results buffered -> fifo_count=0, m_tvalid=0, busy=0. The next 4 beats form a fresh window.
- Random tvalid/tready back-pressure with 1000 windows -> output count 1000, data equal to every 4th input in order, no loss or duplication.

Source files
------------

// File: rtl/pe_result_drain.sv
// Drains the MAC PE result stream: drops intermediate partial sums, keeps every
// ACC_LEN-th beat with the window's OR-ed error flags, and buffers it in a small FIFO.
module pe_result_drain #(
    parameter int ACC_LEN = 4,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_result_tvalid,
    output logic                     s_axis_result_tready,
    input  logic [DATA_W-1:0]        s_axis_result_tdata,
    input  logic [1:0]               s_axis_result_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [1:0]               m_axis_tuser,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 2;
    localparam logic [15:0] LAST_BEAT = 16'(ACC_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [15:0]        r_beat_cnt;
    logic [1:0]         r_err_acc;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ENTRY_W-1:0] r_head;

    logic               w_last_beat;
    logic               w_full;
    logic               w_m_valid;
    logic               w_pop;
    logic               w_s_ready;
    logic               w_accept;
    logic               w_push;
    logic [ENTRY_W-1:0] w_entry;
    logic [PTR_W-1:0]   w_rd_next;

    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_full      = (r_count == FULL_COUNT);
    assign w_m_valid   = (r_count != '0);
    assign w_pop       = w_m_valid & m_axis_tready;

    // Only the closing beat of a window needs FIFO room; a same-cycle pop frees one slot.
    assign w_s_ready   = aresetn & (~w_last_beat | ~w_full | w_pop);
    assign w_accept    = s_axis_result_tvalid & w_s_ready;
    assign w_push      = w_accept & w_last_beat;
    assign w_entry     = {s_axis_result_tdata, r_err_acc | s_axis_result_tuser};
    assign w_rd_next   = r_rd_ptr + PTR_W'(1);

    // NOTE: state registers use non-blocking assignments so every read in this
    // edge sees the pre-edge value, independent of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_beat_cnt <= '0;
            r_err_acc  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
        end else begin
            if (w_accept) begin
                if (w_last_beat) begin
                    r_beat_cnt <= '0;
                    r_err_acc  <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                    r_err_acc  <= r_err_acc | s_axis_result_tuser;
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Head copy changes only on pop or push-into-empty, so the output holds while valid.
            if (w_pop) begin
                if (w_push && (r_wr_ptr == w_rd_next)) begin
                    r_head <= w_entry;
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end else if (w_push && !w_m_valid) begin
                r_head <= w_entry;
            end
        end
    end

    // NOTE: storage has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign s_axis_result_tready = w_s_ready;
    assign m_axis_tvalid        = w_m_valid;
    assign m_axis_tdata         = r_head[ENTRY_W-1:2];
    assign m_axis_tuser         = r_head[1:0];
    assign fifo_count           = r_count;
    assign busy                 = (r_beat_cnt != '0) | w_m_valid;

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: ACC_LEN=4 and ACC_LEN=1 instances,
// each compared every cycle against a queue-based model of the drain rules.
module tb_pe_result_drain;

    localparam int DEPTH = 4;
    localparam int ACC4  = 4;

    logic aclk = 0;
    logic rstn;
    always #5 aclk = ~aclk;

    // ACC_LEN=4 instance
    logic        s_valid4, s_ready4, m_valid4, m_ready4, busy4;
    logic [31:0] s_data4, m_data4;
    logic [1:0]  s_user4, m_user4;
    logic [2:0]  count4;

    // ACC_LEN=1 instance
    logic        s_valid1, s_ready1, m_valid1, m_ready1, busy1;
    logic [31:0] s_data1, m_data1;
    logic [1:0]  s_user1, m_user1;
    logic [2:0]  count1;

    pe_result_drain #(.ACC_LEN(ACC4), .DEPTH(DEPTH), .DATA_W(32)) dut4 (
        .aclk(aclk), .aresetn(rstn),
        .s_axis_result_tvalid(s_valid4), .s_axis_result_tready(s_ready4),
        .s_axis_result_tdata(s_data4), .s_axis_result_tuser(s_user4),
        .m_axis_tvalid(m_valid4), .m_axis_tready(m_ready4),
        .m_axis_tdata(m_data4), .m_axis_tuser(m_user4),
        .fifo_count(count4), .busy(busy4)
    );

    pe_result_drain #(.ACC_LEN(1), .DEPTH(DEPTH), .DATA_W(32)) dut1 (
        .aclk(aclk), .aresetn(rstn),
        .s_axis_result_tvalid(s_valid1), .s_axis_result_tready(s_ready1),
        .s_axis_result_tdata(s_data1), .s_axis_result_tuser(s_user1),
        .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready1),
        .m_axis_tdata(m_data1), .m_axis_tuser(m_user1),
        .fifo_count(count1), .busy(busy1)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a window collects ACC beats; its last beat's data plus the OR of all flags is one result.
    logic [33:0] q4[$], log4[$], q1[$], log1[$];
    int          beats4 = 0;
    logic [1:0]  err4 = 2'b00;
    int          max1 = 0;

    always @(negedge aclk) begin : model4
        logic exp_rdy;
        if (chk_en) begin
            exp_rdy = rstn && (beats4 != ACC4 - 1 || q4.size() < DEPTH || m_ready4);
            check("d4_s_tready", 64'(s_ready4), 64'(exp_rdy));
            check("d4_m_tvalid", 64'(m_valid4), 64'(q4.size() != 0));
            check("d4_fifo_count", 64'(count4), 64'(q4.size()));
            check("d4_busy", 64'(busy4), 64'(beats4 != 0 || q4.size() != 0));
            if (q4.size() != 0) check("d4_head", 64'({m_data4, m_user4}), 64'(q4[0]));
            if (!rstn) begin
                q4.delete();
                beats4 = 0;
                err4 = 2'b00;
            end else begin
                if (q4.size() != 0 && m_ready4) begin
                    log4.push_back({m_data4, m_user4});
                    void'(q4.pop_front());
                end
                if (s_valid4 && exp_rdy) begin
                    if (beats4 == ACC4 - 1) begin
                        q4.push_back({s_data4, err4 | s_user4});
                        beats4 = 0;
                        err4 = 2'b00;
                    end else begin
                        beats4++;
                        err4 = err4 | s_user4;
                    end
                end
            end
        end
    end

    always @(negedge aclk) begin : model1
        logic exp_rdy;
        if (chk_en) begin
            exp_rdy = rstn && (q1.size() < DEPTH || m_ready1);
            check("d1_s_tready", 64'(s_ready1), 64'(exp_rdy));
            check("d1_m_tvalid", 64'(m_valid1), 64'(q1.size() != 0));
            check("d1_fifo_count", 64'(count1), 64'(q1.size()));
            check("d1_busy", 64'(busy1), 64'(q1.size() != 0));
            if (q1.size() != 0) check("d1_head", 64'({m_data1, m_user1}), 64'(q1[0]));
            if (int'(count1) > max1) max1 = int'(count1);
            if (!rstn) begin
                q1.delete();
            end else begin
                if (q1.size() != 0 && m_ready1) begin
                    log1.push_back({m_data1, m_user1});
                    void'(q1.pop_front());
                end
                if (s_valid1 && exp_rdy) q1.push_back({s_data1, s_user1});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send4(input logic [31:0] d, input logic [1:0] u);
        int   budget = 0;
        logic acc;
        s_valid4 = 1'b1;
        s_data4  = d;
        s_user4  = u;
        do begin
            @(negedge aclk);
            acc = s_ready4;
            @(posedge aclk);
            #1;
            budget++;
        end while (!acc && budget < 2000);
        if (!acc) check("send4_accept", 64'(acc), 64'(1));
        s_valid4 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        logic [31:0] finals[5];
        logic [31:0] exp_final[$];
        logic [31:0] d;
        logic        done;
        int          budget;

        rstn = 0;
        s_valid4 = 0; s_data4 = '0; s_user4 = '0; m_ready4 = 0;
        s_valid1 = 0; s_data1 = '0; s_user1 = '0; m_ready1 = 0;
        idle(3);
        chk_en = 1;
        check("rst_m_tdata", 64'(m_data4), 64'(0));
        check("rst_m_tuser", 64'(m_user4), 64'(0));
        check("rst_m_tvalid", 64'(m_valid4), 64'(0));
        check("rst_fifo_count", 64'(count4), 64'(0));
        check("rst_busy", 64'(busy4), 64'(0));
        check("rst_s_tready", 64'(s_ready4), 64'(0));
        rstn = 1;
        idle(1);

        // One clean window: only the 4th beat comes out, the cycle after it is accepted.
        m_ready4 = 1;
        base = log4.size();
        send4(32'h3F800000, 2'b00);
        send4(32'h40400000, 2'b00);
        send4(32'h40C00000, 2'b00);
        check("t1_no_early_valid", 64'(m_valid4), 64'(0));
        send4(32'h41200000, 2'b00);
        check("t1_valid_after_beat4", 64'(m_valid4), 64'(1));
        check("t1_data", 64'(m_data4), 64'(32'h41200000));
        check("t1_user", 64'(m_user4), 64'(0));
        idle(2);
        check("t1_one_output", 64'(log4.size() - base), 64'(1));
        check("t1_logged", 64'(log4[base]), 64'({32'h41200000, 2'b00}));

        // Flags OR across the window, then clear for the next window.
        base = log4.size();
        send4(32'h00000011, 2'b00);
        send4(32'h00000012, 2'b01);
        send4(32'h00000013, 2'b00);
        send4(32'h00000014, 2'b10);
        send4(32'h00000021, 2'b00);
        send4(32'h00000022, 2'b00);
        send4(32'h00000023, 2'b00);
        send4(32'h00000024, 2'b00);
        idle(2);
        check("t2_count", 64'(log4.size() - base), 64'(2));
        check("t2_flags_or", 64'(log4[base]), 64'({32'h00000014, 2'b11}));
        check("t2_flags_clear", 64'(log4[base+1]), 64'({32'h00000024, 2'b00}));

        // Fill the FIFO, stall the 5th window's last beat, then pop+push in one cycle.
        m_ready4 = 0;
        base = log4.size();
        for (int w = 0; w < 5; w++) finals[w] = 32'h1000 + 32'(w * 16 + 3);
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++) send4(32'h1000 + 32'(w * 16 + b), 2'b00);
        idle(1);
        check("t3_full_count", 64'(count4), 64'(4));
        for (int b = 0; b < 3; b++) send4(32'h1040 + 32'(b), 2'b00);
        s_valid4 = 1; s_data4 = finals[4]; s_user4 = 2'b00;
        idle(2);
        @(negedge aclk);
        check("t3_stall_tready", 64'(s_ready4), 64'(0));
        check("t3_stall_count", 64'(count4), 64'(4));
        @(posedge aclk); #1;
        m_ready4 = 1;
        @(negedge aclk);
        check("t3_pop_tready", 64'(s_ready4), 64'(1));
        @(posedge aclk); #1;
        s_valid4 = 0;
        m_ready4 = 0;
        check("t3_popush_count", 64'(count4), 64'(4));
        check("t3_first_out", 64'(log4[base]), 64'({finals[0], 2'b00}));
        m_ready4 = 1;
        idle(8);
        check("t3_drained", 64'(log4.size() - base), 64'(5));
        for (int w = 0; w < 5; w++) check("t3_order", 64'(log4[base+w]), 64'({finals[w], 2'b00}));

        // ACC_LEN=1: every beat is a result, one per cycle.
        m_ready1 = 1;
        s_valid1 = 1;
        for (int i = 0; i < 20; i++) begin
            s_data1 = 32'hA000 + 32'(i);
            s_user1 = 2'(i);
            idle(1);
        end
        s_valid1 = 0;
        idle(3);
        check("t4_out_count", 64'(log1.size()), 64'(20));
        check("t4_max_count_le1", 64'(max1 <= 1), 64'(1));
        for (int i = 0; i < 20; i++) check("t4_data", 64'(log1[i]), 64'({32'hA000 + 32'(i), 2'(i)}));

        // Mid-window reset discards the partial window and buffered results.
        m_ready4 = 0;
        for (int b = 0; b < 8; b++) send4(32'h2000 + 32'(b), 2'b00);
        send4(32'h2100, 2'b01);
        send4(32'h2101, 2'b00);
        check("t5_pre_count", 64'(count4), 64'(2));
        check("t5_pre_busy", 64'(busy4), 64'(1));
        rstn = 0;
        idle(1);
        rstn = 1;
        check("t5_count", 64'(count4), 64'(0));
        check("t5_m_tvalid", 64'(m_valid4), 64'(0));
        check("t5_busy", 64'(busy4), 64'(0));
        m_ready4 = 1;
        base = log4.size();
        for (int b = 0; b < 4; b++) send4(32'h5000 + 32'(b), 2'b00);
        idle(2);
        check("t5_fresh_count", 64'(log4.size() - base), 64'(1));
        check("t5_fresh_window", 64'(log4[base]), 64'({32'h5003, 2'b00}));

        // Random back-pressure, 1000 windows.
        base = log4.size();
        done = 0;
        fork
            begin
                for (int w = 0; w < 1000; w++) begin
                    for (int b = 0; b < 4; b++) begin
                        d = $urandom;
                        if (b == 3) exp_final.push_back(d);
                        if ($urandom_range(0, 3) == 0) begin
                            s_valid4 = 0;
                            idle($urandom_range(1, 3));
                        end
                        send4(d, 2'($urandom_range(0, 3)));
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    m_ready4 = 1'($urandom_range(0, 1));
                    idle(1);
                end
            end
        join
        m_ready4 = 1;
        budget = 0;
        while (q4.size() != 0 && budget < 200) begin
            idle(1);
            budget++;
        end
        idle(1);
        check("t6_out_count", 64'(log4.size() - base), 64'(1000));
        for (int i = 0; i < 1000 && base + i < log4.size(); i++)
            check("t6_data", 64'(log4[base+i][33:2]), 64'(exp_final[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
